ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage pipeline. It consumes the ID/EX register outputs, resolves operand forwarding from EX/MEM and MEM/WB, and computes the ALU result. It also runs a 32-cycle iterative multiplier that stalls upstream while it works. Its EX/MEM pipeline register feeds the memory stage.

## Interface
Parameters:
- `MUL_CYCLES`, default 32: multiplier iterations, one operand bit per cycle.

Ports:
- `clk_i`  in  1: clock. One clock domain; reset is synchronous and active-high.
- `rst_i`  in  1: synchronous, active-high reset.
- `WB_i`  in  2: bit0 RegWrite, bit1 MemtoReg.
- `M_i`  in  2: bit0 MemRead, bit1 MemWrite.
- `ALUOp_i`  in  2: 00 add, 01 sub, 10 R-type (decode funct), 11 or.
- `ALUSrc_i`  in  1: 1 selects the immediate as operand B.
- `RegDst_i`  in  1: 1 selects RD as the destination, 0 selects RT.
- `RSaddr_i`, `RTaddr_i`, `RDaddr_i`  in  5: register addresses.
- `RSdata_i`, `RTdata_i`  in  32: register-file read data.
- `imm_i`  in  32: sign-extended immediate; bits [5:0] are funct.
- `MEMWBRegWrite_i`  in  1: MEM/WB RegWrite.
- `MEMWBRd_i`  in  5: MEM/WB destination.
- `MEMWBdata_i`  in  32: write-back data.
- `stall_o`  out  1: holds PC, IF/ID and ID/EX.
- `WB_o`, `M_o`  out  2: EX/MEM control.
- `ALUresult_o`  out  32: EX/MEM ALU result.
- `RTdata_o`  out  32: forwarded store data.
- `RDaddr_o`  out  5: EX/MEM destination.

## Operation
- Funct decode under ALUOp 10: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x18 mul. Any other funct gives add.
- All arithmetic is 32-bit two's complement and wraps. No overflow flag.
- Mul keeps only the low 32 bits of the product.

Forwarding (per source, for RS and RT):
- If EX/MEM WB[0]=1, `RDaddr_o`≠0 and `RDaddr_o` equals the source, use `ALUresult_o`.
- Otherwise, if `MEMWBRegWrite_i`=1, `MEMWBRd_i`≠0 and `MEMWBRd_i` equals the source, use `MEMWBdata_i`.
- Otherwise use the register-file data.
- EX/MEM has priority over MEM/WB.
- Register 0 is never forwarded.
- Operand B is the immediate when `ALUSrc_i`=1. `RTdata_o` is always the forwarded RT value.

Multiplier FSM, states IDLE, MUL, DONE:
- IDLE to MUL when a mul is present. On entry, the forwarded operands are captured into the multiplicand and multiplier registers, the accumulator is cleared and the counter is set to 0.
- MUL: shift-add one bit per cycle. Move to DONE when counter = `MUL_CYCLES`-1.
- DONE: the accumulator is latched into EX/MEM. Return to IDLE.
- `stall_o` is 1 in IDLE (when the mul is detected) and throughout MUL; it is 0 in DONE.
- Operands are captured at start because forwarding sources keep moving during the stall.

EX/MEM register:
- When `stall_o`=1, a bubble is written: `WB_o`=0, `M_o`=0. Other fields are don't-care and hold.
- Otherwise all fields are latched from the current instruction.

## Timing
- Single-cycle ops: the result appears on the EX/MEM outputs one cycle after the instruction is present at the inputs.
- Mul latency:
  - `stall_o` is high for `MUL_CYCLES`+1 cycles (the detect cycle plus 32 MUL cycles), giving 33 stall cycles at the default.
  - The product is on `ALUresult_o` the cycle after DONE.
  - The total occupancy of EX is 34 cycles.
- `stall_o` is combinational from the state and the mul decode. It must not depend on `MEMWBdata_i`.
- Reset values: state IDLE, counter 0, `stall_o` 0, `WB_o`/`M_o` 0, `ALUresult_o`/`RTdata_o` 0, `RDaddr_o` 0.
- Reset mid-mul: on the next edge the FSM is in IDLE, `stall_o` drops and the partial product is discarded.
- Back-to-back muls: the second is detected in the cycle after DONE with no idle gap.
- A mul whose source is the previous mul's destination forwards from EX/MEM at capture.

## Structure
- Shared package `pipe_pkg`:
  - ALUOp encodings, funct constants, WB/M bit indices, FSM state typedef.
  - Reuse it for `ID_EX` bit indexing.
- Sub-module `mul_iter`: FSM, counter and shift-add datapath, with `start`, `busy` and `done` handshakes.
- Forwarding muxes and ALU stay in the top level.

## Test plan
1. add, RS=5, RT=7, no hazards → `ALUresult_o`=12 one cycle later; `WB_o` equals the input.
2. EX/MEM writes r3=9 and MEM/WB writes r3=4; the next add uses r3+r3 → 18. The same case with rd=0 → the register-file value is used.
3. Immediate or: `ALUOp`=11, RS=0x00F0, imm=0x000F, `ALUSrc`=1 → 0x00FF.
4. Mul: 0xFFFFFFFF×3 → `stall_o` high for exactly 33 cycles with bubbles in EX/MEM, then `ALUresult_o`=0xFFFFFFFD.
5. Reset at MUL cycle 10 → the next cycle has `stall_o`=0 and all outputs 0. A new mul 6×7 then gives 42.
6. Sub wrap: 0x80000000−1 → 0x7FFFFFFF. Unknown funct 0x3F gives add.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU control encodings, control-bit indices,
// ALU function decode and the iterative multiplier state type.
package pipe_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_MUL = 6'h18;

    // Bit positions inside the WB and M control fields of ID/EX and EX/MEM.
    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;
    localparam int M_MEMREAD   = 0;
    localparam int M_MEMWRITE  = 1;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_MUL
    } alu_fn_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DONE
    } mul_state_e;

    function automatic alu_fn_e decode_alu(input logic [1:0] alu_op, input logic [5:0] funct);
        alu_fn_e fn;
        fn = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: fn = ALU_SUB;
            ALUOP_OR:  fn = ALU_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_SUB: fn = ALU_SUB;
                    FUNCT_AND: fn = ALU_AND;
                    FUNCT_OR:  fn = ALU_OR;
                    FUNCT_MUL: fn = ALU_MUL;
                    default:   fn = ALU_ADD;
                endcase
            end
            default: fn = ALU_ADD;
        endcase
        return fn;
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: captures operands on start, consumes one
// multiplier bit per cycle and presents the low 32 product bits in DONE.
module mul_iter
    import pipe_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] multiplicand_i,
    input  logic [31:0] multiplier_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] product_o
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    mul_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      mcand_q;
    logic [31:0]      mplier_q;
    logic [31:0]      acc_q;
    logic             busy_q;
    logic             done_q;

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q  <= ST_MUL;
                        mcand_q  <= multiplicand_i;
                        mplier_q <= multiplier_i;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_MUL: begin
                    acc_q    <= acc_q + (mplier_q[0] ? mcand_q : 32'd0);
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding from EX/MEM and MEM/WB, ALU, iterative
// multiplier with upstream stall, and the EX/MEM pipeline register.
module ex_stage
    import pipe_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  WB_i,
    input  logic [1:0]  M_i,
    input  logic [1:0]  ALUOp_i,
    input  logic        ALUSrc_i,
    input  logic        RegDst_i,
    input  logic [4:0]  RSaddr_i,
    input  logic [4:0]  RTaddr_i,
    input  logic [4:0]  RDaddr_i,
    input  logic [31:0] RSdata_i,
    input  logic [31:0] RTdata_i,
    input  logic [31:0] imm_i,
    input  logic        MEMWBRegWrite_i,
    input  logic [4:0]  MEMWBRd_i,
    input  logic [31:0] MEMWBdata_i,
    output logic        stall_o,
    output logic [1:0]  WB_o,
    output logic [1:0]  M_o,
    output logic [31:0] ALUresult_o,
    output logic [31:0] RTdata_o,
    output logic [4:0]  RDaddr_o
);

    logic [1:0]  wb_q;
    logic [1:0]  m_q;
    logic [31:0] alu_q;
    logic [31:0] rt_q;
    logic [4:0]  rd_q;

    logic [31:0] rs_fwd;
    logic [31:0] rt_fwd;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    alu_fn_e     alu_fn;
    logic        is_mul;
    logic        mul_busy;
    logic        mul_done;
    logic [31:0] mul_product;

    assign alu_fn = decode_alu(ALUOp_i, imm_i[5:0]);
    assign is_mul = (alu_fn == ALU_MUL);

    // EX/MEM wins over MEM/WB; register 0 is never forwarded.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rs_fwd = RSdata_i;
        if (wb_q[WB_REGWRITE] && rd_q != '0 && rd_q == RSaddr_i) begin
            rs_fwd = alu_q;
        end else if (MEMWBRegWrite_i && MEMWBRd_i != '0 && MEMWBRd_i == RSaddr_i) begin
            rs_fwd = MEMWBdata_i;
        end
    end

    always_comb begin
        rt_fwd = RTdata_i;
        if (wb_q[WB_REGWRITE] && rd_q != '0 && rd_q == RTaddr_i) begin
            rt_fwd = alu_q;
        end else if (MEMWBRegWrite_i && MEMWBRd_i != '0 && MEMWBRd_i == RTaddr_i) begin
            rt_fwd = MEMWBdata_i;
        end
    end

    assign op_b = ALUSrc_i ? imm_i : rt_fwd;

    // The mul instruction is held in ID/EX until DONE, so its slot selects the product.
    always_comb begin
        alu_res = rs_fwd + op_b;
        case (alu_fn)
            ALU_SUB: alu_res = rs_fwd - op_b;
            ALU_AND: alu_res = rs_fwd & op_b;
            ALU_OR:  alu_res = rs_fwd | op_b;
            ALU_MUL: alu_res = mul_product;
            default: alu_res = rs_fwd + op_b;
        endcase
    end

    mul_iter #(
        .MUL_CYCLES(MUL_CYCLES)
    ) u_mul_iter (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (is_mul),
        .multiplicand_i (rs_fwd),
        .multiplier_i   (rt_fwd),
        .busy_o         (mul_busy),
        .done_o         (mul_done),
        .product_o      (mul_product)
    );

    assign stall_o = mul_busy | (is_mul & ~mul_done);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_q  <= '0;
            m_q   <= '0;
            alu_q <= '0;
            rt_q  <= '0;
            rd_q  <= '0;
        end else if (stall_o) begin
            wb_q <= '0;
            m_q  <= '0;
        end else begin
            wb_q  <= WB_i;
            m_q   <= M_i;
            alu_q <= alu_res;
            rt_q  <= rt_fwd;
            rd_q  <= RegDst_i ? RDaddr_i : RTaddr_i;
        end
    end

    assign WB_o        = wb_q;
    assign M_o         = m_q;
    assign ALUresult_o = alu_q;
    assign RTdata_o    = rt_q;
    assign RDaddr_o    = rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed plan cases plus randomized ops,
// compared against a behavioural model of the EX/MEM register.
module tb_ex_stage;

    localparam int MUL_CYCLES = 32;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  WB_i, M_i, ALUOp_i;
    logic        ALUSrc_i, RegDst_i;
    logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i;
    logic [31:0] RSdata_i, RTdata_i, imm_i;
    logic        MEMWBRegWrite_i;
    logic [4:0]  MEMWBRd_i;
    logic [31:0] MEMWBdata_i;
    logic        stall_o;
    logic [1:0]  WB_o, M_o;
    logic [31:0] ALUresult_o, RTdata_o;
    logic [4:0]  RDaddr_o;

    int checks = 0;
    int errors = 0;

    // Model of the EX/MEM register contents.
    logic [1:0]  m_wb, m_m;
    logic [31:0] m_alu, m_rt;
    logic [4:0]  m_rd;

    logic [5:0]  funct_tbl [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h3F, 6'h00};
    logic [1:0]  r_op;
    logic [31:0] r_imm;

    ex_stage #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .WB_i(WB_i), .M_i(M_i), .ALUOp_i(ALUOp_i),
        .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .RSaddr_i(RSaddr_i),
        .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i), .RSdata_i(RSdata_i),
        .RTdata_i(RTdata_i), .imm_i(imm_i), .MEMWBRegWrite_i(MEMWBRegWrite_i),
        .MEMWBRd_i(MEMWBRd_i), .MEMWBdata_i(MEMWBdata_i), .stall_o(stall_o),
        .WB_o(WB_o), .M_o(M_o), .ALUresult_o(ALUresult_o), .RTdata_o(RTdata_o),
        .RDaddr_o(RDaddr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_fwd(input logic [4:0] src, input logic [31:0] rf);
        if (m_wb[0] && m_rd != 5'd0 && m_rd == src) return m_alu;
        if (MEMWBRegWrite_i && MEMWBRd_i != 5'd0 && MEMWBRd_i == src) return MEMWBdata_i;
        return rf;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                            input logic [31:0] a, input logic [31:0] b);
        if (op == 2'b01) return a - b;
        if (op == 2'b11) return a | b;
        if (op == 2'b10) begin
            case (f)
                6'h22:   return a - b;
                6'h24:   return a & b;
                6'h25:   return a | b;
                6'h18:   return a * b;
                default: return a + b;
            endcase
        end
        return a + b;
    endfunction

    task automatic set_op(input logic [1:0] wb, input logic [1:0] m, input logic [1:0] op,
                          input logic src, input logic dst, input logic [4:0] rsa,
                          input logic [4:0] rta, input logic [4:0] rda, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic [31:0] imm);
        WB_i = wb; M_i = m; ALUOp_i = op; ALUSrc_i = src; RegDst_i = dst;
        RSaddr_i = rsa; RTaddr_i = rta; RDaddr_i = rda;
        RSdata_i = rsd; RTdata_i = rtd; imm_i = imm;
    endtask

    task automatic set_memwb(input logic we, input logic [4:0] rd, input logic [31:0] data);
        MEMWBRegWrite_i = we; MEMWBRd_i = rd; MEMWBdata_i = data;
    endtask

    task automatic clear_inputs();
        set_op(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        set_memwb(1'b0, 5'd0, 32'd0);
    endtask

    task automatic model_load(input logic [31:0] res, input logic [31:0] rt_f);
        m_wb = WB_i; m_m = M_i; m_alu = res; m_rt = rt_f;
        m_rd = RegDst_i ? RDaddr_i : RTaddr_i;
    endtask

    task automatic check_exmem(input string tag);
        check({tag, " alu"}, ALUresult_o, m_alu);
        check({tag, " rtdata"}, RTdata_o, m_rt);
        check({tag, " ctrl"}, {23'd0, WB_o, M_o, RDaddr_o}, {23'd0, m_wb, m_m, m_rd});
    endtask

    // Called just after a negedge with a non-mul instruction on the inputs.
    task automatic exec_single(input string tag);
        logic [31:0] a, rt_f, res;
        #2;
        a    = model_fwd(RSaddr_i, RSdata_i);
        rt_f = model_fwd(RTaddr_i, RTdata_i);
        res  = ref_alu(ALUOp_i, imm_i[5:0], a, ALUSrc_i ? imm_i : rt_f);
        check({tag, " stall"}, 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        model_load(res, rt_f);
        check_exmem(tag);
        @(negedge clk_i);
    endtask

    // Called just after a negedge with a mul on the inputs; MEM/WB data is
    // scrambled during the stall so only the captured operands can be used.
    task automatic exec_mul(input string tag);
        logic [31:0] prod, rt_f;
        int n;
        bit bubble_ok;
        #2;
        prod = model_fwd(RSaddr_i, RSdata_i) * model_fwd(RTaddr_i, RTdata_i);
        n = 0;
        bubble_ok = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (!stall_o) break;
            n++;
            @(posedge clk_i); #1;
            if (WB_o !== 2'b00 || M_o !== 2'b00) bubble_ok = 1'b0;
            m_wb = 2'b00; m_m = 2'b00;
            MEMWBdata_i = $urandom;
            @(negedge clk_i); #2;
        end
        check({tag, " stall cycles"}, n, MUL_CYCLES + 1);
        check({tag, " bubbles"}, 32'(bubble_ok), 32'd1);
        rt_f = model_fwd(RTaddr_i, RTdata_i);
        @(posedge clk_i); #1;
        model_load(prod, rt_f);
        check_exmem(tag);
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        m_wb = '0; m_m = '0; m_alu = '0; m_rt = '0; m_rd = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset stall", 32'(stall_o), 32'd0);
        check_exmem("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        // Plain add, no hazards.
        set_op(2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 5'd1, 5'd2, 5'd8, 32'd5, 32'd7, 32'd0);
        exec_single("add");
        check("add const", ALUresult_o, 32'd12);
        check("add wb", 32'(WB_o), 32'd1);

        // Forwarding priority and register 0.
        set_op(2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd4, 32'd5, 32'd0);
        exec_single("r3 producer");
        set_op(2'b01, 2'b00, 2'b10, 1'b0, 1'b1, 5'd3, 5'd3, 5'd5, 32'd100, 32'd200, 32'h20);
        set_memwb(1'b1, 5'd3, 32'd4);
        exec_single("fwd exmem prio");
        check("fwd exmem const", ALUresult_o, 32'd18);
        set_op(2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 5'd3, 5'd3, 5'd6, 32'd100, 32'd200, 32'd0);
        exec_single("fwd memwb");
        check("fwd memwb const", ALUresult_o, 32'd8);
        set_op(2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 5'd1, 5'd1, 5'd0, 32'd1, 32'd1, 32'd0);
        exec_single("r0 producer");
        set_op(2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 32'd11, 32'd22, 32'd0);
        set_memwb(1'b1, 5'd0, 32'd4);
        exec_single("r0 no fwd");
        check("r0 const", ALUresult_o, 32'd33);

        // Immediate or, sub wrap, unknown funct, R-type and.
        set_memwb(1'b0, 5'd0, 32'd0);
        set_op(2'b01, 2'b10, 2'b11, 1'b1, 1'b0, 5'd1, 5'd7, 5'd0, 32'h00F0, 32'h1234, 32'h000F);
        exec_single("ori");
        check("ori const", ALUresult_o, 32'h00FF);
        set_op(2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 5'd1, 5'd2, 5'd4, 32'h80000000, 32'd1, 32'd0);
        exec_single("sub wrap");
        check("sub wrap const", ALUresult_o, 32'h7FFFFFFF);
        set_op(2'b01, 2'b00, 2'b10, 1'b0, 1'b1, 5'd1, 5'd2, 5'd4, 32'd10, 32'd20, 32'h3F);
        exec_single("funct 3f");
        check("funct 3f const", ALUresult_o, 32'd30);
        set_op(2'b01, 2'b00, 2'b10, 1'b0, 1'b1, 5'd1, 5'd2, 5'd4, 32'hF0F0, 32'hFF00, 32'h24);
        exec_single("and");
        check("and const", ALUresult_o, 32'hF000);

        // Mul with RT forwarded from MEM/WB at capture, then a dependent back-to-back mul.
        set_op(2'b01, 2'b00, 2'b10, 1'b0, 1'b1, 5'd1, 5'd2, 5'd10, 32'hFFFFFFFF, 32'd99, 32'h18);
        set_memwb(1'b1, 5'd2, 32'd3);
        exec_mul("mul");
        check("mul const", ALUresult_o, 32'hFFFFFFFD);
        set_op(2'b01, 2'b00, 2'b10, 1'b0, 1'b1, 5'd10, 5'd4, 5'd11, 32'd0, 32'd2, 32'h18);
        set_memwb(1'b0, 5'd0, 32'd0);
        exec_mul("mul b2b");
        check("mul b2b const", ALUresult_o, 32'hFFFFFFFA);

        // Reset in the middle of a mul, then a fresh mul.
        set_op(2'b01, 2'b00, 2'b10, 1'b0, 1'b1, 5'd1, 5'd2, 5'd10, 32'h1234, 32'h5678, 32'h18);
        repeat (11) begin
            @(posedge clk_i);
            @(negedge clk_i);
        end
        rst_i = 1'b1;
        clear_inputs();
        @(posedge clk_i); #1;
        m_wb = '0; m_m = '0; m_alu = '0; m_rt = '0; m_rd = '0;
        check("midreset stall", 32'(stall_o), 32'd0);
        check_exmem("midreset");
        @(negedge clk_i);
        rst_i = 1'b0;
        set_op(2'b01, 2'b00, 2'b10, 1'b0, 1'b1, 5'd1, 5'd2, 5'd12, 32'd6, 32'd7, 32'h18);
        exec_mul("mul after reset");
        check("mul 6x7 const", ALUresult_o, 32'd42);

        // Randomized traffic over a small register window to provoke hazards.
        for (int i = 0; i < 40; i++) begin
            r_op  = 2'($urandom_range(0, 3));
            r_imm = $urandom;
            r_imm[5:0] = funct_tbl[$urandom_range(0, 5)];
            if (i % 10 == 9) begin
                r_op = 2'b10;
                r_imm[5:0] = 6'h18;
            end
            set_op(2'($urandom), 2'($urandom), r_op, (r_op == 2'b10) ? 1'b0 : 1'($urandom),
                   1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), $urandom, $urandom, r_imm);
            set_memwb(1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            if (i % 10 == 9) exec_mul("rand mul");
            else exec_single("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
